// File: rtl/serial_adder_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder/subtractor.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Digit counter must hold STEPS-1; a single-step adder still gets one bit.
  function automatic int cnt_width(input int steps);
    return (steps > 1) ? $clog2(steps) : 1;
  endfunction

  function automatic bit params_ok(input int width, input int digit);
    return (width >= 2) && (digit >= 1) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/serial_adder_digit_adder.sv
// Combinational DIGIT-bit adder slice; also exposes the carry into its top bit.
module digit_adder
  import serial_adder_pkg::*;
#(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             ctop
);

  generate
    if (DIGIT == 1) begin : g_single
      assign ctop = cin;
      assign s    = x ^ y ^ cin;
    end else begin : g_multi
      // Add the lower bits separately so the carry into the top bit is visible.
      logic [DIGIT-1:0] low;
      assign low  = {1'b0, x[DIGIT-2:0]} + {1'b0, y[DIGIT-2:0]} + {{(DIGIT-1){1'b0}}, cin};
      assign ctop = low[DIGIT-1];
      assign s    = {x[DIGIT-1] ^ y[DIGIT-1] ^ ctop, low[DIGIT-2:0]};
    end
  endgenerate

  assign co = (x[DIGIT-1] & y[DIGIT-1]) | (ctop & (x[DIGIT-1] ^ y[DIGIT-1]));

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: DIGIT bits per clock, LSD first, with registered carry.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = cnt_width(STEPS);
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  generate
    if (!params_ok(WIDTH, DIGIT)) begin : g_param_err
      $error("serial_adder: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_next;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             msb_cin;
  logic [DIGIT-1:0] d;
  logic             d_co;
  logic             d_top;
  logic             accept;

  digit_adder #(
    .DIGIT(DIGIT)
  ) u_digit (
    .x    (a_sh[DIGIT-1:0]),
    .y    (b_sh[DIGIT-1:0]),
    .cin  (carry),
    .s    (d),
    .co   (d_co),
    .ctop (d_top)
  );

  // New digits enter at the MSB end so the first digit ends up at the LSB.
  always_comb begin
    res_next = res_sh >> DIGIT;
    res_next[WIDTH-1 -: DIGIT] = d;
  end

  assign accept = start && ((state == IDLE) || (state == DONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
      a_sh    <= '0;
      b_sh    <= '0;
      res_sh  <= '0;
      cnt     <= '0;
      carry   <= 1'b0;
      msb_cin <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: ;
        RUN: begin
          res_sh <= res_next;
          a_sh   <= a_sh >> DIGIT;
          b_sh   <= b_sh >> DIGIT;
          carry  <= d_co;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            msb_cin <= d_top;
            busy    <= 1'b0;
            state   <= DONE;
          end
        end
        DONE: begin
          sum   <= res_sh;
          cout  <= carry;
          ovf   <= msb_cin ^ carry;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // Subtraction is A + ~B + 1, so the inverted operand and carry-in are set here.
      if (accept) begin
        state <= RUN;
        busy  <= 1'b1;
        a_sh  <= a;
        b_sh  <= sub ? ~b : b;
        carry <= sub;
        cnt   <= '0;
      end
    end
  end

endmodule
